// File: rtl/uart_tx_arbiter_if.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter_if
// Handshake bundle between the byte-stream requesters, the frame arbiter and
// the UART TX FIFO write port.
//
//   req_data          requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_valid         requester i has a byte
//   req_last          byte from requester i ends its frame
//   req_ready         byte from requester i accepted when valid & ready
//   fifo_ready        TX FIFO can accept a byte
//   tx_data_in        byte written to the TX FIFO
//   tx_data_in_valid  TX FIFO write strobe
//
// master: requester + FIFO side (drives requests and fifo_ready)
// slave : arbiter side
// ---------------------------------------------------------------------------
interface uart_tx_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int NUM_REQ    = 3
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_ready;
    logic [DATA_WIDTH-1:0]         tx_data_in;
    logic                          tx_data_in_valid;

    modport master (
        output req_data, req_valid, req_last, fifo_ready,
        input  req_ready, tx_data_in, tx_data_in_valid
    );

    modport slave (
        input  req_data, req_valid, req_last, fifo_ready,
        output req_ready, tx_data_in, tx_data_in_valid
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
// Frame-level round-robin arbiter sharing the single UART TX FIFO write port
// between NUM_REQ byte-stream requesters. A grant is held for a whole frame
// (ended by a transfer carrying req_last) so frames never interleave on the
// serial line. A stall timeout releases the port if the owner stops sending
// mid-frame for STALL_LIMIT enabled cycles.
//
// Ports:
//   clk     system clock
//   rst_n   asynchronous active-low reset
//   ena     global enable; low freezes all state and blocks transfers
//   bus     uart_tx_arbiter_if.slave (requester handshakes + FIFO port)
//   grant   one-hot current owner, 0 when idle
//   busy    a frame is in progress
//   abort   one-cycle pulse in the cycle a stall-timeout release happens
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
    parameter int DATA_WIDTH  = 8,
    parameter int NUM_REQ     = 3,
    parameter int STALL_LIMIT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ena,
    uart_tx_arbiter_if.slave   bus,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy,
    output logic               abort
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = (STALL_LIMIT > 1) ? $clog2(STALL_LIMIT) : 1;

    typedef enum logic {
        IDLE,
        LOCKED
    } state_t;

    state_t               state_q, state_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [PTR_W-1:0]     owner_q, owner_d;
    logic [PTR_W-1:0]     rr_q, rr_d;
    logic [CNT_W-1:0]     stall_q, stall_d;

    logic                 owner_valid;
    logic                 owner_last;
    logic [DATA_WIDTH-1:0] owner_data;
    logic [PTR_W-1:0]     owner_next;
    logic                 pick_found;
    logic [PTR_W-1:0]     pick_idx;
    logic                 transfer;
    int                   cand;

    // Owner-side view of the requester bus. grant_q is zero when idle, so the
    // reductions naturally read as "no owner activity" outside a frame.
    always_comb begin
        owner_valid = |(bus.req_valid & grant_q);
        owner_last  = |(bus.req_last & grant_q);
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) begin
                owner_data = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
        owner_next = (owner_q == PTR_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
    end

    // Circular search for the first valid requester starting at the rr
    // pointer; the wrap is done with a subtract so NUM_REQ need not be a
    // power of two.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = int'(rr_q) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            if (!pick_found && bus.req_valid[cand[PTR_W-1:0]]) begin
                pick_found = 1'b1;
                pick_idx   = cand[PTR_W-1:0];
            end
        end
    end

    // Next-state and output logic. Both frame end and stall timeout leave
    // through the same release path: back to IDLE, pointer moved past the
    // owner so the next frame goes to someone else first.
    always_comb begin
        state_d              = state_q;
        grant_d              = grant_q;
        owner_d              = owner_q;
        rr_d                 = rr_q;
        stall_d              = stall_q;
        abort                = 1'b0;
        transfer             = 1'b0;
        bus.req_ready        = '0;
        bus.tx_data_in_valid = 1'b0;
        bus.tx_data_in       = '0;

        case (state_q)
            IDLE: begin
                if (ena && pick_found) begin
                    state_d = LOCKED;
                    grant_d = NUM_REQ'(1) << pick_idx;
                    owner_d = pick_idx;
                    stall_d = '0;
                end
            end

            LOCKED: begin
                bus.req_ready        = grant_q & {NUM_REQ{bus.fifo_ready & ena}};
                transfer             = owner_valid & bus.fifo_ready & ena;
                bus.tx_data_in_valid = transfer;
                if (transfer) begin
                    bus.tx_data_in = owner_data;
                    stall_d        = '0;
                    if (owner_last) begin
                        state_d = IDLE;
                        grant_d = '0;
                        rr_d    = owner_next;
                    end
                end else if (ena && !owner_valid) begin
                    // Only a silent owner counts as stalled; a full FIFO
                    // with valid high is ordinary backpressure.
                    if (stall_q == CNT_W'(STALL_LIMIT - 1)) begin
                        abort   = 1'b1;
                        state_d = IDLE;
                        grant_d = '0;
                        rr_d    = owner_next;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State register; ena low needs no term here because the next-state
    // logic already holds every register when ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            owner_q <= '0;
            rr_q    <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            owner_q <= owner_d;
            rr_q    <= rr_d;
            stall_q <= stall_d;
        end
    end

    assign grant = grant_q;
    assign busy  = (state_q == LOCKED);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Frame-level round-robin arbiter that shares the single UART TX FIFO write port (tx_data_in/tx_data_in_valid) between NUM_REQ byte-stream requesters, e.g. the output value generator, a command echo path and a status reporter. A grant is held for a whole frame, delimited by a last flag, so bytes from different requesters never interleave on the serial line. A stall timeout frees the port if a granted requester stops mid-frame.

Parameters:
DATA_WIDTH, 8, byte width per requester and on the FIFO port
NUM_REQ, 3, number of requesters (2..8)
STALL_LIMIT, 1024, idle cycles tolerated mid-frame before forced release

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
ena  input  1  global enable; low freezes all state, no transfers
req_data  input  NUM_REQ*DATA_WIDTH  requester i byte at [i*DATA_WIDTH +: DATA_WIDTH]
req_valid  input  NUM_REQ  requester i has a byte
req_last  input  NUM_REQ  byte from requester i ends its frame
req_ready  output  NUM_REQ  byte from requester i accepted this cycle when valid & ready
fifo_ready  input  1  TX FIFO can accept a byte (not full)
tx_data_in  output  DATA_WIDTH  byte to TX FIFO
tx_data_in_valid  output  1  write strobe to TX FIFO
grant  output  NUM_REQ  one-hot current owner, 0 when idle
busy  output  1  a frame is in progress
abort  output  1  one-cycle pulse on stall-timeout release

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, grant=0, busy=0, abort=0, rr pointer=0, stall counter=0. Combinational outputs follow: req_ready=0, tx_data_in_valid=0, tx_data_in=0.
- States: IDLE, LOCKED.
- IDLE: when ena high and any req_valid, select first i with req_valid[i], searching circularly from the rr pointer; register grant=onehot(i), go LOCKED next cycle. No byte transfers in IDLE, so arbitration latency is 1 cycle.
- LOCKED with owner g: tx_data_in = req_data[g]; tx_data_in_valid = req_valid[g] & fifo_ready & ena; req_ready[g] = fifo_ready & ena; all other req_ready = 0. tx_data_in is 0 whenever tx_data_in_valid is 0.
- A transfer is a cycle where req_valid[g] & req_ready[g]. A transfer with req_last[g] ends the frame: next cycle IDLE, grant=0, rr pointer=(g+1) mod NUM_REQ. A new frame can be granted in the cycle after that, so there is 1 idle cycle between frames.
- Single-byte frame (valid & last on the first byte): legal. The frame completes in one LOCKED cycle.
- Stall counter: cleared on entering LOCKED and on every transfer. Increments each ena cycle in LOCKED when req_valid[g]=0. Cycles where fifo_ready=0 with valid high are backpressure, not stall, and do not count. When the counter reaches STALL_LIMIT-1 and increments again: abort=1 for one cycle, go IDLE, rr pointer advances past g. Later bytes from g start a new frame.
- Fairness: with all requesters continuously valid, grants rotate 0,1,2,0,…; no requester waits more than NUM_REQ-1 frames.
- ena low: state, counter, pointer and grant all hold; req_ready=0; tx_data_in_valid=0; abort is not asserted.
- Requester valid withdrawn or data changed while not ready: tolerated, no error.
- Reset mid-frame: immediate return to IDLE. A partial frame already in the FIFO is not recalled.
- busy = (state == LOCKED).

Test Plan:
- Single requester: req1 sends 0x41,0x42,0x43 (last on 0x43) with fifo_ready=1 -> grant=3'b010 one cycle after req_valid[1]; FIFO receives 41,42,43 on consecutive cycles; grant=0 the cycle after 0x43.
- Contention: all three requesters valid from reset with 2-byte frames -> FIFO sequence is req0 frame, req1 frame, req2 frame, req0 …; no interleaving; 1 idle cycle between frames.
- Backpressure: fifo_ready low for 5 cycles mid-frame -> tx_data_in_valid=0 and req_ready=0 during the gap; no byte lost or duplicated; abort stays 0 even with STALL_LIMIT=4.
- Stall timeout (STALL_LIMIT=4): req0 sends 1 byte without last, then drops valid -> abort pulses on the 4th idle cycle; grant=0 next cycle; pending req1 granted the following cycle.
- ena low mid-frame for 3 cycles -> no transfers; grant held; frame resumes where it stopped once ena rises.
- Async reset asserted mid-frame (between clock edges) -> grant, busy, tx_data_in_valid go 0 immediately; after release, arbitration restarts from requester 0.
